mem_scrub_sweeper: RTL

//  Upstream feeder of the bit-flip monitor. Fills a test SRAM with a known pattern, then sweeps it

---
 rtl/scrub_pkg.sv | 30 +++
 rtl/scrub_timer.sv | 21 ++
 rtl/mem_scrub_sweeper.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/scrub_pkg.sv
// Shared state encoding and expected-word helper for the memory scrub sweeper.
// Macro SCRUB_CHECKERBOARD_EN: odd addresses expect ~PATTERN instead of PATTERN.
package scrub_pkg;

  // Widest word the helper handles; callers zero-extend the pattern and slice the result.
  localparam int SCRUB_MAX_W = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_WR,
    S_RD_REQ,
    S_RD_WAIT,
    S_CHECK,
    S_WB_WR,
    S_WAIT
  } scrub_state_t;

  // Only address parity can change the background, so the lsb is all that is passed in.
  function automatic logic [SCRUB_MAX_W-1:0] expected_word(input logic                   addr,
                                                           input logic [SCRUB_MAX_W-1:0] pattern);
    logic odd_inv;
`ifdef SCRUB_CHECKERBOARD_EN
    odd_inv = 1'b1;
`else
    odd_inv = 1'b0;
`endif
    return (odd_inv && addr) ? ~pattern : pattern;
  endfunction

endpackage

// File: rtl/scrub_timer.sv
// 32-bit down-counter that paces the idle gap between sweeps; saturates at zero.
module scrub_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        cnt_i,
  output logic        zero_o
);

  logic [31:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                         cnt_q <= '0;
    else if (load_i)                   cnt_q <= load_val_i;
    else if (cnt_i && cnt_q != 32'd0)  cnt_q <= cnt_q - 32'd1;
  end

  assign zero_o = (cnt_q == 32'd0);

endmodule

// File: rtl/mem_scrub_sweeper.sv
// Fills a test SRAM with a background pattern, then sweeps it reporting flipped bits and
// rewriting corrupted words. Expected word selection honours SCRUB_CHECKERBOARD_EN (see scrub_pkg).
module mem_scrub_sweeper
  import scrub_pkg::*;
#(
  parameter int                    DATA_WIDTH = 100,
  parameter int                    DEPTH      = 1024,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = '1,
  localparam int                   ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [31:0]           period_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [DATA_WIDTH-1:0] flip_o,
  output logic                  sweep_done_o,
  output logic                  busy_o
);

  scrub_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   flip_q, flip_d, exp_word;
  logic                    sweep_done_q, sweep_done_d;
  logic                    tmr_load, tmr_cnt, tmr_zero;
  logic [31:0]             tmr_load_val;
  logic [SCRUB_MAX_W-1:0]  pat_ext, exp_ext;
  logic                    last_addr, advance;
  logic                    unused_exp_hi;

  always_comb begin
    pat_ext                 = '0;
    pat_ext[DATA_WIDTH-1:0] = PATTERN;
    exp_ext                 = expected_word(addr_q[0], pat_ext);
    exp_word                = exp_ext[DATA_WIDTH-1:0];
  end
  assign unused_exp_hi = ^exp_ext[SCRUB_MAX_W-1:DATA_WIDTH];

  assign last_addr = (addr_q == ADDR_WIDTH'(DEPTH - 1));

  // WAIT is entered holding period_i-1 so that zero_o marks its final cycle.
  scrub_timer u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .cnt_i      (tmr_cnt),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    flip_d       = '0;
    sweep_done_d = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = period_i - 32'd1;
    tmr_cnt      = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_wdata_o  = '0;
    advance      = 1'b0;
    unique case (state_q)
      S_IDLE: if (en_i) begin
        state_d = S_INIT_WR;
        addr_d  = '0;
      end
      S_INIT_WR: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_wdata_o = exp_word;
        if (mem_gnt_i) begin
          addr_d = last_addr ? '0 : addr_q + 1'b1;
          if (last_addr) state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: if (mem_rvalid_i) begin
        flip_d  = mem_rdata_i ^ exp_word;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (flip_q != '0) state_d = S_WB_WR;
        else              advance = 1'b1;
      end
      S_WB_WR: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_wdata_o = exp_word;
        if (mem_gnt_i) advance = 1'b1;
      end
      S_WAIT: begin
        if (!en_i)         state_d = S_IDLE;
        else if (tmr_zero) state_d = S_RD_REQ;
        else               tmr_cnt = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Word boundary: the only place en_i can stop a running sweep.
    if (advance) begin
      if (!en_i) begin
        state_d = S_IDLE;
      end else if (last_addr) begin
        addr_d       = '0;
        sweep_done_d = 1'b1;
        if (period_i == 32'd0) begin
          state_d = S_RD_REQ;
        end else begin
          tmr_load = 1'b1;
          state_d  = S_WAIT;
        end
      end else begin
        addr_d  = addr_q + 1'b1;
        state_d = S_RD_REQ;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      flip_q       <= '0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      flip_q       <= flip_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  assign mem_addr_o   = addr_q;
  assign flip_o       = flip_q;
  assign sweep_done_o = sweep_done_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule
